// File: rtl/rs_issue_queue_pkg.sv
// ============================================================================
//  Module   : rs_issue_queue_pkg
//  Brief    : Shared constants for the reservation issue queues.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rs_issue_queue_pkg;
    localparam int NULL_TAG       = 0;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_TAG_W  = 4;
    localparam int DEFAULT_OP_W   = 2;
    // Per-FU producer ID ranges must never overlap on the CDB.
    localparam int MUL_ID_BASE    = 1;
    localparam int LSU_ID_BASE    = 5;
    localparam int ALU_ID_BASE    = 9;
endpackage

`default_nettype wire

// File: rtl/rs_issue_queue_prienc.sv
// ============================================================================
//  Module   : rs_prienc
//  Brief    : Lowest-set-bit encoder with found flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_prienc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/rs_issue_queue.sv
// ============================================================================
//  Module   : rs_issue_queue
//  Brief    : In-order reservation queue with CDB snoop and private ID pool.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TAG_W   = DEFAULT_TAG_W,
    parameter int OP_W    = DEFAULT_OP_W,
    parameter int ID_BASE = ALU_ID_BASE
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     FLUSH,
    input  logic                     WEN,
    output logic                     isFull,
    output logic [TAG_W-1:0]         allocId,
    input  logic [OP_W-1:0]          opIn,
    input  logic [TAG_W-1:0]         tag1In,
    input  logic [DATA_W-1:0]        data1In,
    input  logic [TAG_W-1:0]         tag2In,
    input  logic [DATA_W-1:0]        data2In,
    input  logic                     BCEN,
    input  logic [TAG_W-1:0]         BClabel,
    input  logic [DATA_W-1:0]        BCdata,
    output logic                     issueValid,
    input  logic                     issueReady,
    output logic [OP_W-1:0]          opOut,
    output logic [DATA_W-1:0]        data1Out,
    output logic [DATA_W-1:0]        data2Out,
    output logic [TAG_W-1:0]         idOut,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TAG_W-1:0] c_null = TAG_W'(NULL_TAG);
    localparam logic [TAG_W-1:0] c_base = TAG_W'(ID_BASE);

    logic [PW-1:0]     r_head, r_tail;
    logic [CW-1:0]     r_count;
    logic [DEPTH-1:0]  r_free;
    logic [OP_W-1:0]   r_op    [DEPTH];
    logic [TAG_W-1:0]  r_tag1  [DEPTH];
    logic [TAG_W-1:0]  r_tag2  [DEPTH];
    logic [DATA_W-1:0] r_data1 [DEPTH];
    logic [DATA_W-1:0] r_data2 [DEPTH];
    logic [PW-1:0]     r_idx   [DEPTH];

    logic             w_nonempty, w_issue_fire, w_enq_fire, w_found;
    logic             w_hit1, w_hit2;
    logic [DEPTH-1:0] w_rel, w_take, w_free_next;
    logic [PW-1:0]    w_alloc_idx;

    assign w_nonempty   = (r_count != '0);
    assign issueValid   = w_nonempty && (r_tag1[r_head] == c_null) && (r_tag2[r_head] == c_null);
    assign w_issue_fire = issueValid & issueReady;
    assign isFull       = (r_count == CW'(DEPTH)) & ~w_issue_fire;

    // The ID leaving with the issuing head is reusable by a same-cycle enqueue.
    assign w_rel = w_issue_fire ? (DEPTH'(1) << r_idx[r_head]) : {DEPTH{1'b0}};

    rs_prienc #(.WIDTH(DEPTH), .IDX_W(PW)) u_prienc (
        .req   (r_free | w_rel),
        .idx   (w_alloc_idx),
        .found (w_found)
    );

    assign allocId     = c_base + TAG_W'(w_alloc_idx);
    assign w_enq_fire  = WEN & ~isFull & ~FLUSH & w_found;
    assign w_take      = w_enq_fire ? (DEPTH'(1) << w_alloc_idx) : {DEPTH{1'b0}};
    assign w_free_next = (r_free | w_rel) & ~w_take;

    assign w_hit1 = BCEN && (tag1In != c_null) && (BClabel == tag1In);
    assign w_hit2 = BCEN && (tag2In != c_null) && (BClabel == tag2In);

    assign opOut    = w_nonempty ? r_op[r_head]    : '0;
    assign data1Out = w_nonempty ? r_data1[r_head] : '0;
    assign data2Out = w_nonempty ? r_data2[r_head] : '0;
    assign idOut    = w_nonempty ? (c_base + TAG_W'(r_idx[r_head])) : '0;
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (RST || FLUSH) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_free  <= '1;
        end else begin
            // Snooping empty slots is harmless: they are rewritten on enqueue.
            for (int i = 0; i < DEPTH; i++) begin
                if (BCEN && (BClabel != c_null) && (r_tag1[i] == BClabel)) begin
                    r_tag1[i]  <= c_null;
                    r_data1[i] <= BCdata;
                end
                if (BCEN && (BClabel != c_null) && (r_tag2[i] == BClabel)) begin
                    r_tag2[i]  <= c_null;
                    r_data2[i] <= BCdata;
                end
            end
            if (w_enq_fire) begin
                r_op[r_tail]    <= opIn;
                r_tag1[r_tail]  <= w_hit1 ? c_null : tag1In;
                r_data1[r_tail] <= w_hit1 ? BCdata : data1In;
                r_tag2[r_tail]  <= w_hit2 ? c_null : tag2In;
                r_data2[r_tail] <= w_hit2 ? BCdata : data2In;
                r_idx[r_tail]   <= w_alloc_idx;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_issue_fire) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_enq_fire) - CW'(w_issue_fire);
            r_free  <= w_free_next;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
// ============================================================================
//  Module   : tb_rs_issue_queue
//  Brief    : Self-checking bench: directed scenarios plus randomized model run.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rs_issue_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int OW    = 2;
    localparam int BASE  = 9;

    logic          clk = 1'b0;
    logic          RST, FLUSH, WEN, BCEN, issueReady;
    logic [OW-1:0] opIn;
    logic [TW-1:0] tag1In, tag2In, BClabel;
    logic [DW-1:0] data1In, data2In, BCdata;
    logic          isFull, issueValid;
    logic [TW-1:0] allocId, idOut;
    logic [OW-1:0] opOut;
    logic [DW-1:0] data1Out, data2Out;
    logic [2:0]    count;

    int n_chk = 0;
    int n_err = 0;

    rs_issue_queue #(.DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .OP_W(OW), .ID_BASE(BASE)) dut (
        .clk(clk), .RST(RST), .FLUSH(FLUSH), .WEN(WEN), .isFull(isFull), .allocId(allocId),
        .opIn(opIn), .tag1In(tag1In), .data1In(data1In), .tag2In(tag2In), .data2In(data2In),
        .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .issueValid(issueValid),
        .issueReady(issueReady), .opOut(opOut), .data1Out(data1Out), .data2Out(data2Out),
        .idOut(idOut), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op; int t1; int d1; int t2; int d2; int id;
    } ent_t;
    ent_t m_q[$];
    bit   m_free[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RST = 0; FLUSH = 0; WEN = 0; BCEN = 0; issueReady = 0;
        opIn = '0; tag1In = '0; tag2In = '0; data1In = '0; data2In = '0;
        BClabel = '0; BCdata = '0;
    endtask

    task automatic enq(input int op, input int t1, input int d1, input int t2, input int d2);
        WEN = 1; opIn = OW'(op); tag1In = TW'(t1); data1In = DW'(d1); tag2In = TW'(t2); data2In = DW'(d2);
    endtask

    task automatic drain();
        idle();
        issueReady = 1;
        repeat (DEPTH + 1) tick();
        issueReady = 0;
    endtask

    task automatic test_reset();
        idle();
        RST = 1;
        tick(); tick();
        RST = 0;
        #1;
        n_chk++; if (issueValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", issueValid); end
        n_chk++; if (isFull !== 1'b0) begin n_err++; $display("FAIL reset_full got=%0b exp=0", isFull); end
        n_chk++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_chk++; if (allocId !== 4'd9) begin n_err++; $display("FAIL reset_alloc got=%0d exp=9", allocId); end
        n_chk++; if ({opOut, data1Out, data2Out, idOut} !== '0) begin n_err++;
            $display("FAIL reset_head got=%0h/%0h/%0h/%0h exp=0", opOut, data1Out, data2Out, idOut); end
    endtask

    task automatic test_basic_issue();
        idle();
        enq(1, 0, 5, 0, 7);
        issueReady = 1;
        #1;
        n_chk++; if (allocId !== 4'd9) begin n_err++; $display("FAIL basic_alloc got=%0d exp=9", allocId); end
        n_chk++; if (issueValid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got=%0b exp=0", issueValid); end
        tick();
        WEN = 0;
        #1;
        n_chk++; if (issueValid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%0b exp=1", issueValid); end
        n_chk++; if (data1Out !== 32'd5 || data2Out !== 32'd7) begin n_err++;
            $display("FAIL basic_data got=%0d,%0d exp=5,7", data1Out, data2Out); end
        n_chk++; if (idOut !== 4'd9 || opOut !== 2'd1) begin n_err++;
            $display("FAIL basic_id_op got=%0d,%0d exp=9,1", idOut, opOut); end
        tick();
        n_chk++; if (count !== 3'd0) begin n_err++; $display("FAIL basic_count got=%0d exp=0", count); end
        idle();
    endtask

    task automatic test_cdb_wakeup();
        idle();
        enq(2, 3, 32'h55, 3, 32'h66);
        tick();
        idle();
        tick();
        BCEN = 1; BClabel = 4'd3; BCdata = 32'hAB;
        #1;
        n_chk++; if (issueValid !== 1'b0) begin n_err++; $display("FAIL wake_no_bypass got=%0b exp=0", issueValid); end
        tick();
        idle();
        #1;
        n_chk++; if (issueValid !== 1'b1) begin n_err++; $display("FAIL wake_valid got=%0b exp=1", issueValid); end
        n_chk++; if (data1Out !== 32'hAB || data2Out !== 32'hAB) begin n_err++;
            $display("FAIL wake_data got=%0h,%0h exp=ab,ab", data1Out, data2Out); end
        drain();
    endtask

    task automatic test_enq_capture();
        idle();
        enq(3, 5, 0, 0, 32'h22);
        BCEN = 1; BClabel = 4'd5; BCdata = 32'h11;
        tick();
        idle();
        #1;
        n_chk++; if (issueValid !== 1'b1) begin n_err++; $display("FAIL capture_valid got=%0b exp=1", issueValid); end
        n_chk++; if (data1Out !== 32'h11 || data2Out !== 32'h22) begin n_err++;
            $display("FAIL capture_data got=%0h,%0h exp=11,22", data1Out, data2Out); end
        drain();
    endtask

    task automatic test_full();
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            enq(k, 0, 100 + k, 0, 200 + k);
            #1;
            n_chk++; if (allocId !== TW'(BASE + k)) begin n_err++;
                $display("FAIL full_alloc k=%0d got=%0d exp=%0d", k, allocId, BASE + k); end
            tick();
        end
        enq(1, 0, 32'h77, 0, 32'h77);
        #1;
        n_chk++; if (isFull !== 1'b1 || count !== 3'd4) begin n_err++;
            $display("FAIL full_flag got=%0b,%0d exp=1,4", isFull, count); end
        tick();
        n_chk++; if (count !== 3'd4 || idOut !== 4'd9 || data1Out !== 32'd100) begin n_err++;
            $display("FAIL full_ignored got=%0d,%0d,%0d exp=4,9,100", count, idOut, data1Out); end
        enq(2, 0, 32'h99, 0, 32'h98);
        issueReady = 1;
        #1;
        n_chk++; if (isFull !== 1'b0 || allocId !== 4'd9) begin n_err++;
            $display("FAIL full_reuse got=%0b,%0d exp=0,9", isFull, allocId); end
        tick();
        idle();
        #1;
        n_chk++; if (count !== 3'd4 || idOut !== 4'd10) begin n_err++;
            $display("FAIL full_after_reuse got=%0d,%0d exp=4,10", count, idOut); end
        issueReady = 1;
        repeat (3) tick();
        issueReady = 0;
        #1;
        n_chk++; if (idOut !== 4'd9 || data1Out !== 32'h99 || count !== 3'd1) begin n_err++;
            $display("FAIL full_wrap got=%0d,%0h,%0d exp=9,99,1", idOut, data1Out, count); end
        drain();
    endtask

    task automatic test_flush();
        idle();
        enq(1, 6, 0, 0, 1); tick();
        enq(1, 0, 2, 0, 3); tick();
        enq(1, 0, 4, 0, 5); tick();
        FLUSH = 1;
        enq(2, 0, 9, 0, 9);
        issueReady = 1;
        tick();
        idle();
        #1;
        n_chk++; if (count !== 3'd0 || issueValid !== 1'b0 || allocId !== 4'd9) begin n_err++;
            $display("FAIL flush_state got=%0d,%0b,%0d exp=0,0,9", count, issueValid, allocId); end
        BCEN = 1; BClabel = 4'd6; BCdata = 32'h1234;
        tick();
        idle();
        #1;
        n_chk++; if (count !== 3'd0 || issueValid !== 1'b0) begin n_err++;
            $display("FAIL flush_stale_bc got=%0d,%0b exp=0,0", count, issueValid); end
    endtask

    task automatic test_rst_midfill();
        idle();
        enq(1, 0, 1, 0, 1); tick();
        enq(1, 0, 2, 0, 2); tick();
        idle();
        RST = 1;
        tick();
        RST = 0;
        #1;
        n_chk++; if (count !== 3'd0 || issueValid !== 1'b0 || isFull !== 1'b0 || allocId !== 4'd9
                     || idOut !== 4'd0 || data1Out !== 32'd0) begin n_err++;
            $display("FAIL rst_mid got=%0d,%0b,%0b,%0d,%0d exp=0,0,0,9,0", count, issueValid, isFull, allocId, idOut); end
        enq(3, 0, 42, 0, 43);
        #1;
        n_chk++; if (allocId !== 4'd9) begin n_err++; $display("FAIL rst_realloc got=%0d exp=9", allocId); end
        tick();
        idle();
        #1;
        n_chk++; if (idOut !== 4'd9 || data1Out !== 32'd42) begin n_err++;
            $display("FAIL rst_reenq got=%0d,%0d exp=9,42", idOut, data1Out); end
        drain();
    endtask

    function automatic int rnd_tag();
        return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
    endfunction

    task automatic test_random();
        bit e_valid, e_fire, e_full;
        int e_alloc;
        ent_t n;
        idle();
        FLUSH = 1; tick(); FLUSH = 0;
        m_q.delete();
        for (int id = 0; id < 16; id++) m_free[id] = (id >= BASE && id < BASE + DEPTH);
        for (int cyc = 0; cyc < 400; cyc++) begin
            WEN = ($urandom_range(0, 1) == 1);
            FLUSH = ($urandom_range(0, 39) == 0);
            issueReady = ($urandom_range(0, 9) < 6);
            BCEN = ($urandom_range(0, 1) == 1);
            BClabel = TW'($urandom_range(0, 12));
            BCdata = $urandom;
            opIn = OW'($urandom);
            tag1In = TW'(rnd_tag()); tag2In = TW'(rnd_tag());
            data1In = $urandom; data2In = $urandom;
            #1;
            e_valid = (m_q.size() > 0) && m_q[0].t1 == 0 && m_q[0].t2 == 0;
            e_fire  = e_valid && issueReady;
            e_full  = (m_q.size() == DEPTH) && !e_fire;
            e_alloc = BASE;
            for (int id = BASE + DEPTH - 1; id >= BASE; id--)
                if (m_free[id] || (e_fire && m_q[0].id == id)) e_alloc = id;
            n_chk++; if (issueValid !== e_valid) begin n_err++;
                $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, issueValid, e_valid); end
            n_chk++; if (isFull !== e_full) begin n_err++;
                $display("FAIL rnd_full cyc=%0d got=%0b exp=%0b", cyc, isFull, e_full); end
            n_chk++; if (int'(count) != m_q.size()) begin n_err++;
                $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, m_q.size()); end
            if (!e_full) begin
                n_chk++; if (int'(allocId) != e_alloc) begin n_err++;
                    $display("FAIL rnd_alloc cyc=%0d got=%0d exp=%0d", cyc, allocId, e_alloc); end
            end
            if (e_valid) begin
                n_chk++; if (int'(opOut) != m_q[0].op || data1Out !== DW'(m_q[0].d1)
                             || data2Out !== DW'(m_q[0].d2) || int'(idOut) != m_q[0].id) begin n_err++;
                    $display("FAIL rnd_head cyc=%0d got=%0d,%0h,%0h,%0d exp=%0d,%0h,%0h,%0d", cyc,
                             opOut, data1Out, data2Out, idOut, m_q[0].op, m_q[0].d1, m_q[0].d2, m_q[0].id); end
            end
            if (FLUSH) begin
                m_q.delete();
                for (int id = BASE; id < BASE + DEPTH; id++) m_free[id] = 1;
            end else begin
                for (int i = 0; i < m_q.size(); i++) begin
                    if (BCEN && BClabel != 0 && m_q[i].t1 == int'(BClabel)) begin m_q[i].t1 = 0; m_q[i].d1 = int'(BCdata); end
                    if (BCEN && BClabel != 0 && m_q[i].t2 == int'(BClabel)) begin m_q[i].t2 = 0; m_q[i].d2 = int'(BCdata); end
                end
                if (e_fire) begin m_free[m_q[0].id] = 1; void'(m_q.pop_front()); end
                if (WEN && !e_full) begin
                    n.op = int'(opIn); n.id = e_alloc;
                    n.t1 = int'(tag1In); n.d1 = int'(data1In);
                    n.t2 = int'(tag2In); n.d2 = int'(data2In);
                    if (BCEN && n.t1 != 0 && n.t1 == int'(BClabel)) begin n.t1 = 0; n.d1 = int'(BCdata); end
                    if (BCEN && n.t2 != 0 && n.t2 == int'(BClabel)) begin n.t2 = 0; n.d2 = int'(BCdata); end
                    m_q.push_back(n);
                    m_free[e_alloc] = 0;
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_basic_issue();
        test_cdb_wakeup();
        test_enq_capture();
        test_full();
        test_flush();
        test_rst_midfill();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
